// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion and multi-cycle mul/div sequencing.
// Holds the F/D and D/X latches while the multdiv unit runs, then releases the result into X/M.
module stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] irFD,
  input  logic [31:0] irDX,
  input  logic        mdRdy,
  input  logic        mdExcep,
  output logic        stallFD,
  output logic        stallDX,
  output logic        flushDX,
  output logic        mdStartMult,
  output logic        mdStartDiv,
  output logic        mdLatchEn,
  output logic        mdExcepOut,
  output logic        busy
);

  localparam logic [4:0] OpRType = 5'b00000;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] AluMul  = 5'b00110;
  localparam logic [4:0] AluDiv  = 5'b00111;
  localparam logic [5:0] CntLast = 6'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StBusy  = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       exc_q, exc_d;
  logic       div_q, div_d;

  logic [4:0] fd_op, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       is_md, is_div, load_use;
  logic       unused_bits;

  assign fd_op  = irFD[31:27];
  assign fd_rs  = irFD[21:17];
  assign fd_rt  = irFD[16:12];
  assign dx_op  = irDX[31:27];
  assign dx_rd  = irDX[26:22];
  assign dx_alu = irDX[6:2];

  assign unused_bits = ^{irFD[26:22], irFD[11:0], irDX[21:7], irDX[1:0]};

  assign is_md    = (dx_op == OpRType) && ((dx_alu == AluMul) || (dx_alu == AluDiv));
  assign is_div   = (dx_alu == AluDiv);
  // Only R-type consumers read rt as a source; immediates reuse that field as a destination.
  assign load_use = (dx_op == OpLw) && (dx_rd != 5'd0) &&
                    ((fd_rs == dx_rd) || ((fd_op == OpRType) && (fd_rt == dx_rd)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exc_d       = exc_q;
    div_d       = div_q;
    stallFD     = 1'b0;
    stallDX     = 1'b0;
    flushDX     = 1'b0;
    mdStartMult = 1'b0;
    mdStartDiv  = 1'b0;
    mdLatchEn   = 1'b0;
    mdExcepOut  = 1'b0;
    busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (is_md) begin
          stallFD = 1'b1;
          stallDX = 1'b1;
          div_d   = is_div;
          state_d = StStart;
        end else if (load_use) begin
          stallFD = 1'b1;
          flushDX = 1'b1;
        end
      end
      StStart: begin
        stallFD     = 1'b1;
        stallDX     = 1'b1;
        mdStartMult = ~div_q;
        mdStartDiv  = div_q;
        cnt_d       = 6'd0;
        exc_d       = 1'b0;
        state_d     = StBusy;
      end
      StBusy: begin
        stallFD = 1'b1;
        stallDX = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (mdRdy) begin
          exc_d   = mdExcep;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          // No answer from multdiv: complete anyway and flag the result as bad.
          exc_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        mdLatchEn  = 1'b1;
        mdExcepOut = exc_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      exc_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: vector table driven cycle by cycle, expected outputs
// queued at drive time and popped when sampled on the falling edge.
module tb_stall_ctrl;

  localparam int unsigned TO = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] irFD, irDX;
  logic        mdRdy, mdExcep;
  logic        stallFD, stallDX, flushDX, mdStartMult, mdStartDiv;
  logic        mdLatchEn, mdExcepOut, busy;

  stall_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .irFD        (irFD),
    .irDX        (irDX),
    .mdRdy       (mdRdy),
    .mdExcep     (mdExcep),
    .stallFD     (stallFD),
    .stallDX     (stallDX),
    .flushDX     (flushDX),
    .mdStartMult (mdStartMult),
    .mdStartDiv  (mdStartDiv),
    .mdLatchEn   (mdLatchEn),
    .mdExcepOut  (mdExcepOut),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Output bit order: {stallFD, stallDX, flushDX, startMult, startDiv, latchEn, excepOut, busy}
  localparam logic [7:0] E_NONE  = 8'b0000_0000;
  localparam logic [7:0] E_MDIDL = 8'b1100_0000;
  localparam logic [7:0] E_LU    = 8'b1010_0000;
  localparam logic [7:0] E_STMUL = 8'b1101_0001;
  localparam logic [7:0] E_STDIV = 8'b1100_1001;
  localparam logic [7:0] E_BUSY  = 8'b1100_0001;
  localparam logic [7:0] E_DONE  = 8'b0000_0101;
  localparam logic [7:0] E_DONEX = 8'b0000_0111;

  typedef struct {
    logic        rst;
    logic [31:0] fd;
    logic [31:0] dx;
    logic        rdy;
    logic        exc;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    mk = {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  logic [31:0] nop_i, mul_i, div_i, lw3_i, lw0_i, add_rs3, add_rt3, addi_rt3;

  task automatic add(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                     input logic rdy, input logic exc, input logic [7:0] exp, input string nm);
    vec_t v;
    v.rst = rst; v.fd = fd; v.dx = dx; v.rdy = rdy; v.exc = exc; v.exp = exp; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] got, e;
    string      nm;
    reset   = v.rst;
    irFD    = v.fd;
    irDX    = v.dx;
    mdRdy   = v.rdy;
    mdExcep = v.exc;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clock);
    got = {stallFD, stallDX, flushDX, mdStartMult, mdStartDiv, mdLatchEn, mdExcepOut, busy};
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (vector %0d)", nm, got, e, n_vec);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    nop_i    = 32'd0;
    mul_i    = mk(5'b00000, 5'd5, 5'd1, 5'd2, 5'b00110);
    div_i    = mk(5'b00000, 5'd6, 5'd1, 5'd2, 5'b00111);
    lw3_i    = mk(5'b01000, 5'd3, 5'd1, 5'd0, 5'b00000);
    lw0_i    = mk(5'b01000, 5'd0, 5'd1, 5'd0, 5'b00000);
    add_rs3  = mk(5'b00000, 5'd7, 5'd3, 5'd1, 5'b00000);
    add_rt3  = mk(5'b00000, 5'd7, 5'd1, 5'd3, 5'b00000);
    addi_rt3 = mk(5'b00101, 5'd7, 5'd4, 5'd3, 5'b00000);

    // Reset; load-use term is combinational in IDLE even while reset is low.
    add(0, nop_i, nop_i, 1, 1, E_NONE, "reset_idle");
    add(0, nop_i, nop_i, 0, 0, E_NONE, "reset_idle2");
    add(0, add_rs3, lw3_i, 0, 0, E_LU, "reset_lu_comb");
    add(1, nop_i, nop_i, 1, 1, E_NONE, "post_reset_rdy_ignored");

    // mul, mdRdy at cycle 6
    add(1, nop_i, mul_i, 0, 0, E_MDIDL, "mul_c0");
    add(1, nop_i, mul_i, 1, 1, E_STMUL, "mul_c1_start_rdy_ignored");
    for (int c = 2; c <= 5; c++) add(1, nop_i, mul_i, 0, 0, E_BUSY, $sformatf("mul_c%0d", c));
    add(1, nop_i, mul_i, 1, 0, E_BUSY, "mul_c6_rdy");
    add(1, nop_i, mul_i, 0, 0, E_DONE, "mul_c7_done");
    add(1, nop_i, nop_i, 0, 0, E_NONE, "mul_c8_idle");

    // Load-use
    add(1, add_rs3, lw3_i, 0, 0, E_LU, "lu_rs");
    add(1, addi_rt3, lw3_i, 0, 0, E_NONE, "lu_addi_rt_nostall");
    add(1, add_rt3, lw3_i, 0, 0, E_LU, "lu_rtype_rt");
    add(1, mk(5'b00000, 5'd7, 5'd0, 5'd0, 5'd0), lw0_i, 0, 0, E_NONE, "lu_rd0");
    add(1, add_rs3, nop_i, 0, 0, E_NONE, "lu_not_lw");

    // div timeout: DONE exactly TO cycles after first BUSY cycle
    add(1, nop_i, div_i, 0, 0, E_MDIDL, "to_c0");
    add(1, nop_i, div_i, 0, 0, E_STDIV, "to_start");
    for (int c = 0; c < int'(TO); c++)
      add(1, nop_i, div_i, 0, 0, E_BUSY, $sformatf("to_busy%0d", c));
    add(1, nop_i, div_i, 0, 0, E_DONEX, "to_done_exc");
    add(1, nop_i, nop_i, 0, 0, E_NONE, "to_idle");

    // mul then div back-to-back; captured exception must clear
    add(1, add_rs3, mul_i, 0, 0, E_MDIDL, "b2b_mul_c0");
    add(1, add_rs3, mul_i, 0, 0, E_STMUL, "b2b_mul_start");
    add(1, add_rs3, mul_i, 1, 0, E_BUSY, "b2b_mul_rdy");
    add(1, add_rs3, mul_i, 0, 0, E_DONE, "b2b_mul_done");
    add(1, add_rs3, div_i, 0, 0, E_MDIDL, "b2b_div_c0");
    add(1, add_rs3, div_i, 0, 0, E_STDIV, "b2b_div_start");
    add(1, add_rs3, div_i, 0, 0, E_BUSY, "b2b_div_busy");
    add(1, add_rs3, div_i, 1, 0, E_BUSY, "b2b_div_rdy");
    add(1, add_rs3, div_i, 0, 0, E_DONE, "b2b_div_done");

    // div with exception reported by multdiv
    add(1, nop_i, div_i, 0, 0, E_MDIDL, "dexc_c0");
    add(1, nop_i, div_i, 0, 0, E_STDIV, "dexc_start");
    add(1, nop_i, div_i, 1, 1, E_BUSY, "dexc_rdy");
    add(1, nop_i, div_i, 0, 1, E_DONEX, "dexc_done");
    add(1, nop_i, nop_i, 0, 0, E_NONE, "dexc_notbusy");

    // Reset in BUSY, then late mdRdy
    add(1, nop_i, div_i, 0, 0, E_MDIDL, "rb_c0");
    add(1, nop_i, div_i, 0, 0, E_STDIV, "rb_start");
    add(1, nop_i, div_i, 0, 0, E_BUSY, "rb_busy");
    add(0, nop_i, nop_i, 0, 0, E_BUSY, "rb_reset_edge");
    add(1, nop_i, nop_i, 1, 1, E_NONE, "rb_late_rdy");
    add(1, nop_i, nop_i, 1, 1, E_NONE, "rb_late_rdy2");

    reset = 1'b0; irFD = '0; irDX = '0; mdRdy = 1'b0; mdExcep = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
